// File: rtl/nrs_pkg.sv
// Shared constants, state encoding and LFSR step helper for the NRS Gold-sequence generator.
package nrs_pkg;

    localparam int CINIT_W    = 31;
    localparam int NC_DEFAULT = 1600;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Feedback taps: x1 new bit = x1[3]^x1[0], x2 new bit = x2[3]^x2[2]^x2[1]^x2[0]
    localparam logic [CINIT_W-1:0] X1_TAPS = 31'h0000_0009;
    localparam logic [CINIT_W-1:0] X2_TAPS = 31'h0000_000F;

    function automatic logic [CINIT_W-1:0] lfsr_step(input logic [CINIT_W-1:0] x,
                                                     input logic [CINIT_W-1:0] taps);
        return {^(x & taps), x[CINIT_W-1:1]};
    endfunction

endpackage

// File: rtl/gold_lfsr_adv.sv
// Combinational N-step advance of the x1/x2 Gold-sequence LFSR pair.
module gold_lfsr_adv
    import nrs_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [CINIT_W-1:0] x1_i,
    input  logic [CINIT_W-1:0] x2_i,
    output logic [CINIT_W-1:0] x1_o,
    output logic [CINIT_W-1:0] x2_o
);

    logic [CINIT_W-1:0] x1_v;
    logic [CINIT_W-1:0] x2_v;

    always_comb begin
        x1_v = x1_i;
        x2_v = x2_i;
        for (int i = 0; i < N; i++) begin
            x1_v = lfsr_step(x1_v, X1_TAPS);
            x2_v = lfsr_step(x2_v, X2_TAPS);
        end
        x1_o = x1_v;
        x2_o = x2_v;
    end

endmodule

// File: rtl/nrs_gold_seq_gen.sv
// Gold sequence c(n) generator: STEP-per-cycle warm-up over NC bits, then c(n) streamed as bit pairs.
module nrs_gold_seq_gen
    import nrs_pkg::*;
#(
    parameter int NC   = NC_DEFAULT,
    parameter int STEP = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cinit_valid,
    input  logic [CINIT_W-1:0] cinit,
    output logic               cinit_ready,
    input  logic               stop,
    input  logic               pair_ready,
    output logic               pair_valid,
    output logic [1:0]         pair,
    output logic               busy
);

    localparam int WARM_CYC = NC / STEP;
    localparam int WCNT_W   = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARM_CYC - 1);

    state_e              state_q, state_d;
    logic [CINIT_W-1:0]  x1_q, x1_d;
    logic [CINIT_W-1:0]  x2_q, x2_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                rdy_en_q;
    logic [CINIT_W-1:0]  x1_warm, x2_warm;
    logic [CINIT_W-1:0]  x1_run, x2_run;

    gold_lfsr_adv #(.N(STEP)) u_adv_warm (
        .x1_i (x1_q),
        .x2_i (x2_q),
        .x1_o (x1_warm),
        .x2_o (x2_warm)
    );

    gold_lfsr_adv #(.N(2)) u_adv_run (
        .x1_i (x1_q),
        .x2_i (x2_q),
        .x1_o (x1_run),
        .x2_o (x2_run)
    );

    // rdy_en_q keeps cinit_ready low while reset is held without an input-to-output path
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x1_q     <= 31'h1;
            x2_q     <= '0;
            wcnt_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            wcnt_q   <= wcnt_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        wcnt_d  = wcnt_q;
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cinit_valid && rdy_en_q) begin
                        x1_d    = 31'h1;
                        x2_d    = cinit;
                        wcnt_d  = '0;
                        state_d = WARM;
                    end
                end
                WARM: begin
                    x1_d   = x1_warm;
                    x2_d   = x2_warm;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (wcnt_q == WCNT_LAST) state_d = RUN;
                end
                RUN: begin
                    // Reload supersedes the advance; a same-cycle handshake is simply consumed
                    if (cinit_valid) begin
                        x1_d    = 31'h1;
                        x2_d    = cinit;
                        wcnt_d  = '0;
                        state_d = WARM;
                    end else if (pair_ready) begin
                        x1_d = x1_run;
                        x2_d = x2_run;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cinit_ready = rdy_en_q && (state_q != WARM);
        pair_valid  = (state_q == RUN);
        busy        = (state_q == WARM);
        pair        = (state_q == RUN) ? {x1_q[0] ^ x2_q[0], x1_q[1] ^ x2_q[1]} : 2'b00;
    end

endmodule

// File: tb/tb_nrs_gold_seq_gen.sv
// Scoreboard bench: two instances (STEP=8 and STEP=1) checked against a bitwise Gold-sequence model.
module tb_nrs_gold_seq_gen;
    import nrs_pkg::*;

    localparam int NC = 1600;
    localparam logic [30:0] C0 = 31'h0;
    localparam logic [30:0] C1 = 31'h1234567;
    localparam logic [30:0] C2 = 31'h2B3C4D5E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_cv, a_cr, a_stop, a_prdy, a_pv, a_busy;
    logic [30:0] a_ci;
    logic [1:0]  a_pair;
    logic        b_rst, b_cv, b_cr, b_stop, b_prdy, b_pv, b_busy;
    logic [30:0] b_ci;
    logic [1:0]  b_pair;

    int checks = 0;
    int errors = 0;
    logic [1:0] qa[$];
    logic [1:0] qb[$];

    nrs_gold_seq_gen #(.NC(NC), .STEP(8)) u_dut_a (
        .clk(clk), .rst(a_rst), .cinit_valid(a_cv), .cinit(a_ci), .cinit_ready(a_cr),
        .stop(a_stop), .pair_ready(a_prdy), .pair_valid(a_pv), .pair(a_pair), .busy(a_busy)
    );

    nrs_gold_seq_gen #(.NC(NC), .STEP(1)) u_dut_b (
        .clk(clk), .rst(b_rst), .cinit_valid(b_cv), .cinit(b_ci), .cinit_ready(b_cr),
        .stop(b_stop), .pair_ready(b_prdy), .pair_valid(b_pv), .pair(b_pair), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Straight 36.211 recurrence over bit arrays; pair m = {c(2m), c(2m+1)}
    task automatic push_gold(input logic [30:0] ci, input int m0, input int cnt, input bit to_b);
        bit x1 [0:8191];
        bit x2 [0:8191];
        int top;
        bit c0, c1;
        top = NC + 2 * (m0 + cnt) + 2;
        for (int i = 0; i < 31; i++) begin
            x1[i] = (i == 0);
            x2[i] = ci[i];
        end
        for (int n = 0; n + 31 < top; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int m = m0; m < m0 + cnt; m++) begin
            c0 = x1[NC+2*m]   ^ x2[NC+2*m];
            c1 = x1[NC+2*m+1] ^ x2[NC+2*m+1];
            if (to_b) qb.push_back({c0, c1});
            else      qa.push_back({c0, c1});
        end
    endtask

    logic       a_stall_q = 1'b0;
    logic [1:0] a_held    = 2'b00;

    always @(negedge clk) begin
        logic [1:0] e;
        if (a_pv && a_prdy) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pairA: got unexpected pair %b, required none (queue empty)", a_pair);
            end else begin
                e = qa.pop_front();
                chk("pairA", 32'(a_pair), 32'(e));
            end
        end
        if (a_stall_q && a_pv) chk("holdA", 32'(a_pair), 32'(a_held));
        a_stall_q = a_pv && !a_prdy;
        a_held    = a_pair;
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (b_pv && b_prdy) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pairB: got unexpected pair %b, required none (queue empty)", b_pair);
            end else begin
                e = qb.pop_front();
                chk("pairB", 32'(b_pair), 32'(e));
            end
        end
    end

    task automatic wait_valid_a(input int exp_cyc);
        int cyc = 0;
        while (!a_pv && cyc < exp_cyc + 50) begin
            tick();
            cyc++;
        end
        chk("latencyA", 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic drain_a();
        int g = 0;
        a_prdy = 1'b1;
        while (qa.size() > 0 && g < 5000) begin
            tick();
            g++;
        end
        a_prdy = 1'b0;
        chk("drainA_left", 32'(qa.size()), 32'd0);
    endtask

    task automatic stall_drain_a();
        logic [15:0] pat = 16'b1001_1010_0110_1001;
        int g = 0;
        while (qa.size() > 0 && g < 5000) begin
            a_prdy = pat[g % 16];
            tick();
            g++;
        end
        a_prdy = 1'b0;
        chk("stallA_left", 32'(qa.size()), 32'd0);
    endtask

    task automatic reset_checks_a(input string tag);
        chk({tag, "_pv"},   32'(a_pv),   32'd0);
        chk({tag, "_busy"}, 32'(a_busy), 32'd0);
        chk({tag, "_pair"}, 32'(a_pair), 32'd0);
        chk({tag, "_crdy"}, 32'(a_cr),   32'd0);
    endtask

    task automatic seq_a();
        int g;
        repeat (3) tick();
        reset_checks_a("rst0");
        a_rst = 1'b0;
        tick();
        chk("rel_crdy", 32'(a_cr), 32'd1);
        chk("rel_pv",   32'(a_pv), 32'd0);

        // cinit=0: x1-only m-sequence
        push_gold(C0, 0, 64, 0);
        a_prdy = 1'b1;
        a_ci   = C0;
        a_cv   = 1'b1;
        tick();
        a_cv = 1'b0;
        chk("warm_busy", 32'(a_busy), 32'd1);
        chk("warm_crdy", 32'(a_cr),   32'd0);
        wait_valid_a(200);
        chk("run_crdy", 32'(a_cr),   32'd1);
        chk("run_busy", 32'(a_busy), 32'd0);
        drain_a();

        // Stalled consumption continues the same stream
        push_gold(C0, 64, 48, 0);
        stall_drain_a();

        // Reload after 10 more pairs, handshake in the reload cycle consumes the 11th
        push_gold(C0, 112, 11, 0);
        a_prdy = 1'b1;
        g = 0;
        while (qa.size() > 1 && g < 100) begin
            tick();
            g++;
        end
        a_ci = C1;
        a_cv = 1'b1;
        tick();
        a_cv = 1'b0;
        chk("reload_busy", 32'(a_busy), 32'd1);
        push_gold(C1, 0, 1000, 0);
        wait_valid_a(200);
        drain_a();

        // stop mid-WARM
        a_ci = C2;
        a_cv = 1'b1;
        tick();
        a_cv = 1'b0;
        repeat (50) tick();
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        chk("stop_busy", 32'(a_busy), 32'd0);
        chk("stop_pv",   32'(a_pv),   32'd0);
        chk("stop_crdy", 32'(a_cr),   32'd1);
        repeat (5) tick();
        chk("idle_pv", 32'(a_pv), 32'd0);

        // stop in IDLE is ignored; the restart matches an uninterrupted run
        a_stop = 1'b1;
        a_cv   = 1'b1;
        a_ci   = C2;
        tick();
        a_stop = 1'b0;
        a_cv   = 1'b0;
        chk("idlestop_busy", 32'(a_busy), 32'd1);
        push_gold(C2, 0, 40, 0);
        wait_valid_a(200);
        drain_a();

        // stop beats a same-cycle reload in RUN
        a_stop = 1'b1;
        a_cv   = 1'b1;
        a_ci   = C1;
        tick();
        a_stop = 1'b0;
        a_cv   = 1'b0;
        chk("stopwin_busy", 32'(a_busy), 32'd0);
        chk("stopwin_pv",   32'(a_pv),   32'd0);

        // Reset mid-RUN
        a_ci = C1;
        a_cv = 1'b1;
        tick();
        a_cv = 1'b0;
        push_gold(C1, 0, 5, 0);
        wait_valid_a(200);
        drain_a();
        a_rst = 1'b1;
        tick();
        reset_checks_a("rstrun");
        a_rst = 1'b0;
        tick();
        chk("rstrun_rel_crdy", 32'(a_cr), 32'd1);
        chk("rstrun_rel_pv",   32'(a_pv), 32'd0);

        // Reset mid-WARM
        a_ci = C0;
        a_cv = 1'b1;
        tick();
        a_cv = 1'b0;
        repeat (30) tick();
        a_rst = 1'b1;
        tick();
        reset_checks_a("rstwarm");
        a_rst = 1'b0;
        tick();
        chk("rstwarm_rel_crdy", 32'(a_cr),   32'd1);
        chk("rstwarm_rel_busy", 32'(a_busy), 32'd0);

        a_ci = C2;
        a_cv = 1'b1;
        tick();
        a_cv = 1'b0;
        push_gold(C2, 0, 20, 0);
        wait_valid_a(200);
        drain_a();
    endtask

    task automatic seq_b();
        int cyc = 0;
        int g   = 0;
        repeat (2) tick();
        b_rst = 1'b0;
        tick();
        b_ci = C1;
        b_cv = 1'b1;
        tick();
        b_cv = 1'b0;
        push_gold(C1, 0, 1000, 1);
        while (!b_pv && cyc < 1700) begin
            tick();
            cyc++;
        end
        chk("latencyB", 32'(cyc), 32'd1600);
        b_prdy = 1'b1;
        while (qb.size() > 0 && g < 5000) begin
            tick();
            g++;
        end
        b_prdy = 1'b0;
        chk("drainB_left", 32'(qb.size()), 32'd0);
    endtask

    initial begin
        a_rst = 1'b1; a_cv = 1'b0; a_ci = '0; a_stop = 1'b0; a_prdy = 1'b0;
        b_rst = 1'b1; b_cv = 1'b0; b_ci = '0; b_stop = 1'b0; b_prdy = 1'b0;
        fork
            seq_a();
            seq_b();
        join
        repeat (3) tick();
        chk("final_qa", 32'(qa.size()), 32'd0);
        chk("final_qb", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/nrs_gold_seq_gen.md
# nrs_gold_seq_gen

Consumes the 31-bit `cinit` produced by the NRS cinit computation, and generates the length-31 Gold sequence c(n) of 36.211 §7.2 from it. The block skips the first NC bits in a multi-bit-per-cycle warm-up, then streams c(n) as bit pairs, c(2m) and c(2m+1), to the NRS QPSK mapper. It is the reader side of the cinit interface, and the first sequential stage of the NRS value generator.

## Interface
- `NC`, 1600: Gold-sequence offset, in bits skipped before output.
- `STEP`, 8: LFSR advances per warm-up cycle. Must divide NC and lie in 1..16.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cinit_valid` in 1: cinit offered.
- `cinit` in 31: initial x2 state, with bit i = x2(i).
- `cinit_ready` out 1: block can accept cinit.
- `stop` in 1: single-cycle pulse that ends the stream and returns the block to IDLE.
- `pair_ready` in 1: downstream accepts the pair.
- `pair_valid` out 1: the pair is valid.
- `pair` out 2: bit1 = c(2m), bit0 = c(2m+1).
- `busy` out 1: high in WARM.

## Operation
- Both LFSR registers are 31 bits. Bit j holds x(n+j).
  - Advance rule: shift right by one, inserting the new bit at bit 30.
  - x1 new bit = x1[3]^x1[0].
  - x2 new bit = x2[3]^x2[2]^x2[1]^x2[0].
- State IDLE:
  - cinit_ready=1, pair_valid=0.
  - On cinit_valid: x1←31'h1, x2←cinit, wcnt←0, go to WARM.
- State WARM:
  - Each cycle, advance both LFSRs by STEP and increment wcnt.
  - When wcnt reaches NC/STEP−1, go to RUN on that same edge.
  - cinit_ready=0. cinit_valid is ignored.
- State RUN:
  - pair_valid=1.
  - pair = {x1[0]^x2[0], x1[1]^x2[1]}.
  - On pair_valid&pair_ready, advance both LFSRs by 2.
  - Without pair_ready, the pair holds stable.
  - cinit_ready=1. On cinit_valid: reload as in IDLE and go to WARM. A same-cycle pair handshake still counts as consumed.
- stop:
  - In WARM or RUN, stop goes to IDLE and wins over a same-cycle handshake or reload.
  - stop is ignored in IDLE.
- Reset behaviour:
  - Reset values: state=IDLE, x1=31'h1, x2=0, wcnt=0. Outputs cinit_ready=0 during reset, 1 afterwards; pair_valid=0; pair=2'b00 (gated to 0 outside RUN); busy=0.
  - Reset mid-WARM or mid-RUN discards all state with no residual output.
- The stream never terminates on its own; there is no wrap limit. The downstream counts pairs.

## Timing
- cinit accepted at edge k → busy high from edge k through edge k+NC/STEP−1.
- First pair_valid follows edge k+NC/STEP. The default is 200 cycles.
- Output rate is one pair per cycle under continuous pair_ready, with zero bubbles.
- pair depends only on registers; there is no combinational path from pair_ready to pair or pair_valid.
- cinit_ready is decoded from state only, with no input dependence.

## Structure
- Package `nrs_pkg` holds:
  - `CINIT_W`=31 and `NC_DEFAULT`=1600.
  - The state enum {IDLE, WARM, RUN}.
  - x1/x2 tap masks.
- Sub-module `gold_lfsr_adv` (parameter N) does combinational N-step advance of the x1/x2 pair.
  - Instantiated twice: N=STEP for warm-up, N=2 for run.
  - The FSM, wcnt and output registers stay in the top.
- wcnt width = $clog2(NC/STEP).

## Test plan
- cinit=31'h0, STEP=8, pair_ready=1:
  - pair_valid rises exactly 200 cycles after accept.
  - The first 64 pairs equal x1-only m-sequence bits n=1600..1727 from the golden 36.211 model.
- cinit=31'h1234567 run with STEP=1 and with STEP=8:
  - First 1000 pairs are identical and match the golden model.
  - First valid arrives after 1600 and 200 cycles respectively.
- pair_ready toggled 1,0,0,1 pseudo-randomly:
  - pair holds stable while stalled.
  - The sequence matches the golden model with no skipped or duplicated pairs.
- Reload in RUN after 10 pairs, with cinit_valid and pair_ready high together:
  - busy rises next cycle.
  - The new stream starts with c(1600) of the new cinit.
- stop asserted mid-WARM (cycle 50), then cinit_valid with the same cinit:
  - Back in IDLE with pair_valid=0.
  - The restarted output is identical to an uninterrupted run.
- rst asserted mid-RUN and mid-WARM:
  - Next cycle: pair_valid=0, busy=0, pair=0.
  - After release, cinit_ready=1 with the state reinitialised.
